// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8 data bits, LSB first, optional parity, one stop bit.
// Recovers bytes from the asynchronous rx pin, strobes rx_flag for each good
// byte and pulses frame_err / parity_err for bad frames.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_flag,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          mism_q;
  logic          sync1_q;
  logic          sync2_q;
  logic [7:0]    data_q;
  logic          flag_q;
  logic          ferr_q;
  logic          perr_q;

  // Synchronizer, bit-timing counter and receive FSM with registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mism_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      data_q  <= '0;
      flag_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      flag_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          bit_q  <= '0;
          mism_q <= 1'b0;
          if (!sync2_q) state_q <= START;
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            // A line back high at mid-start-bit is a glitch, not a frame.
            state_q <= sync2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            mism_q  <= (^shift_q) ^ sync2_q ^ PAR_ODD;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (sync2_q) begin
              if (mism_q) begin
                perr_q <= 1'b1;
              end else begin
                data_q <= shift_q;
                flag_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              perr_q  <= mism_q;
              state_q <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          // Hold off until the line returns high so a stuck-low line
          // cannot retrigger the receiver.
          cnt_q <= '0;
          if (sync2_q) state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data    = data_q;
  assign rx_flag    = flag_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: an 8N1 instance and an even-parity
// instance, both at 16 clocks per bit. Expected events (cycle + kind + byte)
// are computed from the frame timing rules and compared against a monitor.
module tb_uart_rx_deserializer;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       rx_m = 1'b1;
  logic       rx_p = 1'b1;
  logic [7:0] data_m, data_p;
  logic       flag_m, ferr_m, perr_m, busy_m;
  logic       flag_p, ferr_p, perr_p, busy_p;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .rx(rx_m), .rx_data(data_m), .rx_flag(flag_m),
    .frame_err(ferr_m), .parity_err(perr_m), .busy(busy_m)
  );

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .rx(rx_p), .rx_data(data_p), .rx_flag(flag_p),
    .frame_err(ferr_p), .parity_err(perr_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_e = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= rst;
  end

  // Events encoded as cycle*1024 + kind*256 + byte (kind 1 flag, 2 ferr, 3 perr).
  int         act_m[$], act_p[$], exp_m[$], exp_p[$];
  int         vectors = 0, miscompares = 0, overlap = 0, unstable = 0;
  logic [7:0] prev_m = '0, prev_p = '0, good_m = '0, good_p = '0;

  always @(negedge clk) begin
    if (flag_m) act_m.push_back(cyc * 1024 + 256 + int'(data_m));
    if (ferr_m) act_m.push_back(cyc * 1024 + 512);
    if (perr_m) act_m.push_back(cyc * 1024 + 768);
    if (flag_p) act_p.push_back(cyc * 1024 + 256 + int'(data_p));
    if (ferr_p) act_p.push_back(cyc * 1024 + 512);
    if (perr_p) act_p.push_back(cyc * 1024 + 768);
    if (flag_m && (ferr_m || perr_m)) overlap++;
    if (flag_p && (ferr_p || perr_p)) overlap++;
    if (!rst_e && !flag_m && data_m !== prev_m) unstable++;
    if (!rst_e && !flag_p && data_p !== prev_p) unstable++;
    prev_m = data_m;
    prev_p = data_p;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int which, input int ev);
    if (which == 0) exp_m.push_back(ev);
    else exp_p.push_back(ev);
  endtask

  // Reference: outcome and timing of one frame whose start edge hit the pin in cycle f.
  task automatic model(input int which, input int f, input logic [7:0] b,
                       input int pe, input logic pbit, input logic stop);
    int   t;
    logic bad;
    t   = f + 2 + HALF + (9 + pe) * CPB + 1;
    bad = (pe != 0) && (((^b) ^ pbit) != 1'b0);
    if (stop) begin
      if (bad) push_exp(which, t * 1024 + 768);
      else begin
        push_exp(which, t * 1024 + 256 + int'(b));
        if (which == 0) good_m = b;
        else good_p = b;
      end
    end else begin
      push_exp(which, t * 1024 + 512);
      if (bad) push_exp(which, t * 1024 + 768);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_m = v;
    else rx_p = v;
  endtask

  task automatic bit_out(input int which, input logic v, output int at);
    @(negedge clk);
    set_line(which, v);
    at = cyc;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send(input int which, input logic [7:0] b, input int pe,
                      input logic pbit, input logic stop, output int f);
    int d;
    bit_out(which, 1'b0, f);
    for (int i = 0; i < 8; i++) bit_out(which, b[i], d);
    if (pe != 0) bit_out(which, pbit, d);
    bit_out(which, stop, d);
    model(which, f, b, pe, pbit, stop);
  endtask

  task automatic cmp(input int which, input string tag);
    int a[$], e[$], n;
    if (which == 0) begin
      a = act_m; e = exp_m; act_m.delete(); exp_m.delete();
    end else begin
      a = act_p; e = exp_p; act_p.delete(); exp_p.delete();
    end
    check({tag, " event count"}, a.size(), e.size());
    n = (a.size() < e.size()) ? a.size() : e.size();
    for (int i = 0; i < n; i++) check({tag, " event"}, a[i], e[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int         f, r, d;
    logic [7:0] b;
    logic       pb, sb;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst rx_data", data_m, 8'h00);
    check("rst rx_flag", flag_m, 1'b0);
    check("rst frame_err", ferr_m, 1'b0);
    check("rst parity_err", perr_m, 1'b0);
    check("rst busy", busy_m, 1'b0);
    check("rst par busy", busy_p, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(20);

    // Single 8N1 frame
    send(0, 8'hFE, 0, 1'b0, 1'b1, f);
    idle(20);
    cmp(0, "single FE");
    check("single FE data", data_m, 8'hFE);

    // Back-to-back header bytes followed by random back-to-back bytes
    send(0, 8'hFE, 0, 1'b0, 1'b1, f);
    send(0, 8'h0B, 0, 1'b0, 1'b1, f);
    send(0, 8'h04, 0, 1'b0, 1'b1, f);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send(0, b, 0, 1'b0, 1'b1, f);
    end
    idle(20);
    cmp(0, "back-to-back");
    check("b2b last data", data_m, good_m);

    // Start-bit glitch of 5 cycles
    @(negedge clk);
    rx_m = 1'b0;
    f = cyc;
    idle(5);
    rx_m = 1'b1;
    idle(f + 2 + HALF - cyc);
    check("glitch busy at sample", busy_m, 1'b1);
    idle(1);
    check("glitch busy after sample", busy_m, 1'b0);
    idle(30);
    cmp(0, "glitch");

    // Framing error with line held low, then recovery
    send(0, 8'h55, 0, 1'b0, 1'b0, f);
    idle(40);
    rx_m = 1'b1;
    r = cyc;
    idle(2);
    check("break busy held", busy_m, 1'b1);
    idle(1);
    check("break busy released", busy_m, 1'b0);
    check("ferr data held", data_m, good_m);
    idle(20);
    send(0, 8'hA5, 0, 1'b0, 1'b1, f);
    idle(20);
    cmp(0, "frame error");
    check("after break data", data_m, 8'hA5);

    // Even parity: good then bad parity on 0x07
    send(1, 8'h07, 1, 1'b1, 1'b1, f);
    send(1, 8'h07, 1, 1'b0, 1'b1, f);
    idle(20);
    cmp(1, "parity 07");
    check("parity data", data_p, 8'h07);
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      send(1, b, 1, pb, sb, f);
      @(negedge clk);
      rx_p = 1'b1;
      idle(30);
    end
    cmp(1, "parity random");
    check("parity random data", data_p, good_p);

    // Reset during data bit 4 of 0x3C, then 0x81
    b = 8'h3C;
    bit_out(0, 1'b0, f);
    for (int i = 0; i < 4; i++) bit_out(0, b[i], d);
    @(negedge clk);
    rx_m = b[4];
    idle(8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    good_m = 8'h00;
    good_p = 8'h00;
    check("mid rst rx_data", data_m, 8'h00);
    check("mid rst rx_flag", flag_m, 1'b0);
    check("mid rst frame_err", ferr_m, 1'b0);
    check("mid rst parity_err", perr_m, 1'b0);
    check("mid rst busy", busy_m, 1'b0);
    rx_m = 1'b1;
    idle(40);
    send(0, 8'h81, 0, 1'b0, 1'b1, f);
    idle(20);
    cmp(0, "after reset");
    cmp(1, "par idle");
    check("after reset data", data_m, 8'h81);

    check("flag/error overlap", overlap, 0);
    check("rx_data stability", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
